pe_mac_seq: RTL and testbench

Self-sequencing processing element for the CNN accelerator array. It holds private kernel and neuron local stores and generates its own read addresses (base plus stride). Each start command runs one dot product of programmable length into a wide accumulator. It then adds the incoming partial sum and presents the W-bit result on a valid/ready output port. It is the parametrised successor of the original PE, which only did a single combinational multiply-add per cycle under external address control.

---
 rtl/pe_mac_seq.sv | 155 +++++++++++++++
 tb/tb_pe_mac_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_seq.sv
// Self-sequencing MAC processing element: private kernel/neuron stores, strided address
// generation, wide accumulator, partial-sum add. Define PE_SATURATE_EN to clamp the result.
module pe_mac_seq #(
    parameter int unsigned W     = 16,
    parameter int unsigned A     = 7,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 2 * W + A
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] kernelIn,
    input  logic         kernelWrite,
    input  logic [A-1:0] kernelWrAddr,
    input  logic [W-1:0] neuronIn,
    input  logic         neuronWrite,
    input  logic [A-1:0] neuronWrAddr,
    input  logic         start,
    input  logic [A:0]   len,
    input  logic [A-1:0] kernelBase,
    input  logic [A-1:0] neuronBase,
    input  logic [A-1:0] kernelStride,
    input  logic [A-1:0] neuronStride,
    input  logic [W-1:0] adderIn,
    output logic [W-1:0] adderOut,
    output logic         outValid,
    input  logic         outReady,
    output logic         busy
);

    localparam int unsigned Depth = 2 ** A;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

    state_e state_q, state_d;

    logic [W-1:0] kmem [Depth];
    logic [W-1:0] nmem [Depth];
    logic [W-1:0] k_rd_q, n_rd_q;

    logic [A:0]   len_q, idx_q;
    logic [A-1:0] ka_q, na_q, kstride_q, nstride_q;
    logic [W-1:0] adder_q, out_q;

    logic signed [ACC_W-1:0] acc_q, acc_sum, acc_shift;
    logic signed [2*W-1:0]   k_ext, n_ext, prod;
    logic signed [ACC_W:0]   sum_wide;
    logic [W-1:0]            res;

    logic cmd_accept, last_issue, acc_en;

    assign cmd_accept = start && (state_q == StIdle) && (len != '0);
    assign last_issue = (idx_q == len_q - (A + 1)'(1));

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_accept) state_d = StRun;
            StRun:   if (last_issue) state_d = StDrain;
            StDrain: state_d = StHold;
            StHold:  if (outReady) state_d = StIdle;
        endcase
    end

    // Outputs; the first RUN cycle has no product in flight yet
    always_comb begin
        busy     = (state_q != StIdle);
        outValid = (state_q == StHold);
        acc_en   = ((state_q == StRun) && (idx_q != '0)) || (state_q == StDrain);
    end

    // Stores are not reset; nonblocking read gives old data on a same-cycle write
    always_ff @(posedge CLK) begin
        if (kernelWrite) kmem[kernelWrAddr] <= kernelIn;
        if (neuronWrite) nmem[neuronWrAddr] <= neuronIn;
        k_rd_q <= kmem[ka_q];
        n_rd_q <= nmem[na_q];
    end

    always_comb begin
        k_ext     = {{W{k_rd_q[W-1]}}, k_rd_q};
        n_ext     = {{W{n_rd_q[W-1]}}, n_rd_q};
        prod      = k_ext * n_ext;
        acc_sum   = acc_q + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
        acc_shift = acc_sum >>> FRAC;
        sum_wide  = {acc_shift[ACC_W-1], acc_shift}
                  + {{(ACC_W + 1 - W){adder_q[W-1]}}, adder_q};
    end

`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_W:0] SatMax = {{(ACC_W + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SatMin = {{(ACC_W + 2 - W){1'b1}}, {(W - 1){1'b0}}};

    always_comb begin
        if (sum_wide > SatMax) begin
            res = SatMax[W-1:0];
        end else if (sum_wide < SatMin) begin
            res = SatMin[W-1:0];
        end else begin
            res = sum_wide[W-1:0];
        end
    end
`else
    logic unused_sum_hi;

    assign unused_sum_hi = ^sum_wide[ACC_W:W];
    assign res           = sum_wide[W-1:0];
`endif

    // Command latch, address generation, accumulator, result register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            len_q     <= '0;
            idx_q     <= '0;
            ka_q      <= '0;
            na_q      <= '0;
            kstride_q <= '0;
            nstride_q <= '0;
            adder_q   <= '0;
            acc_q     <= '0;
            out_q     <= '0;
        end else begin
            if (cmd_accept) begin
                len_q     <= len;
                idx_q     <= '0;
                ka_q      <= kernelBase;
                na_q      <= neuronBase;
                kstride_q <= kernelStride;
                nstride_q <= neuronStride;
                adder_q   <= adderIn;
                acc_q     <= '0;
            end else begin
                if (acc_en) acc_q <= acc_sum;
                if (state_q == StRun) begin
                    idx_q <= idx_q + (A + 1)'(1);
                    ka_q  <= ka_q + kstride_q;
                    na_q  <= na_q + nstride_q;
                end
            end
            if (state_q == StDrain) out_q <= res;
        end
    end

    assign adderOut = out_q;

endmodule

// File: tb/tb_pe_mac_seq.sv
// Bench for pe_mac_seq: two instances (FRAC=0 and FRAC=8) sharing stimulus, checked every
// cycle against a schedule-level model plus hand-computed literals.
module tb_pe_mac_seq;

    localparam int W = 16;
    localparam int A = 7;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] kernelIn, neuronIn, adderIn;
    logic         kernelWrite, neuronWrite, start, outReady;
    logic [A-1:0] kernelWrAddr, neuronWrAddr, kernelBase, neuronBase;
    logic [A-1:0] kernelStride, neuronStride;
    logic [A:0]   len;
    logic [W-1:0] adderOut0, adderOut8;
    logic         outValid0, outValid8, busy0, busy8;

    always #5 CLK = ~CLK;

    pe_mac_seq #(.W(W), .A(A), .FRAC(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .kernelIn(kernelIn), .kernelWrite(kernelWrite), .kernelWrAddr(kernelWrAddr),
        .neuronIn(neuronIn), .neuronWrite(neuronWrite), .neuronWrAddr(neuronWrAddr),
        .start(start), .len(len), .kernelBase(kernelBase), .neuronBase(neuronBase),
        .kernelStride(kernelStride), .neuronStride(neuronStride), .adderIn(adderIn),
        .adderOut(adderOut0), .outValid(outValid0), .outReady(outReady), .busy(busy0)
    );

    pe_mac_seq #(.W(W), .A(A), .FRAC(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N),
        .kernelIn(kernelIn), .kernelWrite(kernelWrite), .kernelWrAddr(kernelWrAddr),
        .neuronIn(neuronIn), .neuronWrite(neuronWrite), .neuronWrAddr(neuronWrAddr),
        .start(start), .len(len), .kernelBase(kernelBase), .neuronBase(neuronBase),
        .kernelStride(kernelStride), .neuronStride(neuronStride), .adderIn(adderIn),
        .adderOut(adderOut8), .outValid(outValid8), .outReady(outReady), .busy(busy8)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] kmod [128];
    logic [15:0] nmod [128];
    bit          m_busy, m_valid;
    int          m_cnt, m_len, m_kb, m_ks, m_nb, m_ns;
    logic [15:0] m_adder, m_out0, m_out8;
    longint      m_acc;

    function automatic logic [15:0] finalize(input longint acc, input int frac,
                                             input logic [15:0] adder);
        longint s;
        s = (acc >>> frac) + longint'($signed(adder));
`ifdef PE_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic model_step();
        int ka, na;
        if (!RST_N) begin
            m_busy = 0; m_valid = 0; m_out0 = '0; m_out8 = '0; m_acc = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (start && len != 0) begin
                m_len = int'(len); m_kb = int'(kernelBase); m_ks = int'(kernelStride);
                m_nb = int'(neuronBase); m_ns = int'(neuronStride); m_adder = adderIn;
                m_busy = 1; m_cnt = 0; m_acc = 0;
            end
        end else if (!m_valid) begin
            if (m_cnt < m_len) begin
                // read j happens at edge T(j+1), before that edge's writes land
                ka = (m_kb + m_cnt * m_ks) % 128;
                na = (m_nb + m_cnt * m_ns) % 128;
                m_acc += longint'($signed(kmod[ka])) * longint'($signed(nmod[na]));
                m_cnt++;
            end else begin
                m_out0  = finalize(m_acc, 0, m_adder);
                m_out8  = finalize(m_acc, 8, m_adder);
                m_valid = 1;
            end
        end else if (outReady) begin
            m_valid = 0; m_busy = 0;
        end
        if (kernelWrite) kmod[kernelWrAddr] = kernelIn;
        if (neuronWrite) nmod[neuronWrAddr] = neuronIn;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            kmod[i] = '0;
            nmod[i] = '0;
        end
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (armed) begin
                check("valid0", 32'(outValid0), 32'(m_valid));
                check("valid8", 32'(outValid8), 32'(m_valid));
                check("busy0", 32'(busy0), 32'(m_busy));
                check("busy8", 32'(busy8), 32'(m_busy));
                check("out0", 32'(adderOut0), 32'(m_out0));
                check("out8", 32'(adderOut8), 32'(m_out8));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_k(input int addr, input logic [15:0] data);
        kernelWrite = 1; kernelWrAddr = A'(addr); kernelIn = data;
        tick();
        kernelWrite = 0;
    endtask

    task automatic wr_n(input int addr, input logic [15:0] data);
        neuronWrite = 1; neuronWrAddr = A'(addr); neuronIn = data;
        tick();
        neuronWrite = 0;
    endtask

    task automatic run_cmd(input int l, input int kb, input int ks, input int nb, input int ns,
                           input logic [15:0] adder);
        len = (A + 1)'(l); kernelBase = A'(kb); kernelStride = A'(ks);
        neuronBase = A'(nb); neuronStride = A'(ns); adderIn = adder;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!outValid0 && cycles < 50) begin
            tick();
            cycles++;
        end
        check("valid_timeout", 32'(outValid0), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        RST_N = 0; kernelIn = '0; neuronIn = '0; adderIn = '0; kernelWrite = 0;
        neuronWrite = 0; kernelWrAddr = '0; neuronWrAddr = '0; start = 0; len = '0;
        kernelBase = '0; neuronBase = '0; kernelStride = '0; neuronStride = '0;
        outReady = 1;
        tick();
        tick();
        check("rst_valid", 32'(outValid0), 32'(0));
        check("rst_busy", 32'(busy0), 32'(0));
        check("rst_out", 32'(adderOut0), 32'(0));
        RST_N = 1;
        armed = 1;

        // basic MAC: 1*5+2*6+3*7+4*8 + 10 = 80
        for (int i = 0; i < 4; i++) begin
            wr_k(i, 16'(i + 1));
            wr_n(i, 16'(i + 5));
        end
        run_cmd(4, 0, 1, 0, 1, 16'd10);
        check("start_busy", 32'(busy0), 32'(1));
        wait_valid(cyc);
        check("latency", 32'(cyc), 32'(6));
        check("mac80", 32'(adderOut0), 32'(80));
        check("mac_frac8", 32'(adderOut8), 32'(10));
        tick();
        check("pulse_one", 32'(outValid0), 32'(0));
        check("idle_after", 32'(busy0), 32'(0));

        // len=0 is ignored
        run_cmd(0, 0, 1, 0, 1, 16'd0);
        check("len0_ignored", 32'(busy0), 32'(0));

        // stride and wrap: 3*5 + (-2)*7 + 1*10 - 4 = 7
        wr_k(126, 16'd3);
        wr_k(127, 16'hFFFE);
        wr_n(4, 16'd10);
        run_cmd(3, 126, 1, 0, 2, 16'hFFFC);
        wait_valid(cyc);
        check("wrap7", 32'(adderOut0), 32'(7));
        check("wrap_frac8", 32'(adderOut8), 32'hFFFC);
        tick();

        // backpressure with start pulses, then start coincident with handshake
        outReady = 0;
        run_cmd(4, 0, 1, 0, 1, 16'd0);
        wait_valid(cyc);
        len = (A + 1)'(1);
        start = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", 32'(adderOut0), 32'(70));
            check("bp_busy", 32'(busy0), 32'(1));
        end
        outReady = 1;
        tick();
        start = 0;
        check("bp_release", 32'(busy0), 32'(0));

        // write collision: neuron[3] old value 1 is read, new value 9 lands after
        wr_n(3, 16'd1);
        run_cmd(4, 0, 1, 0, 1, 16'd0);
        tick();
        tick();
        tick();
        neuronWrite = 1; neuronWrAddr = A'(3); neuronIn = 16'd9;
        tick();
        neuronWrite = 0;
        wait_valid(cyc);
        check("coll_old", 32'(adderOut0), 32'(42));
        tick();
        run_cmd(4, 0, 1, 0, 1, 16'd0);
        wait_valid(cyc);
        check("coll_new", 32'(adderOut0), 32'(74));
        tick();

        // reset during HOLD, then a len=1 command: 1*5 + 2 = 7
        outReady = 0;
        run_cmd(2, 0, 1, 0, 1, 16'd0);
        wait_valid(cyc);
        tick();
        RST_N = 0;
        tick();
        check("hold_rst_valid", 32'(outValid0), 32'(0));
        check("hold_rst_busy", 32'(busy0), 32'(0));
        check("hold_rst_out", 32'(adderOut0), 32'(0));
        RST_N = 1;
        outReady = 1;
        run_cmd(1, 0, 1, 0, 1, 16'd2);
        wait_valid(cyc);
        check("len1_latency", 32'(cyc), 32'(3));
        check("len1", 32'(adderOut0), 32'(7));
        tick();

        // saturation / wrap of the final add
        wr_k(0, 16'h7FFF);
        wr_k(1, 16'h7FFF);
        wr_n(0, 16'h7FFF);
        wr_n(1, 16'h7FFF);
        run_cmd(2, 0, 1, 0, 1, 16'h7FFF);
        wait_valid(cyc);
`ifdef PE_SATURATE_EN
        check("sat", 32'(adderOut0), 32'h7FFF);
        check("sat_frac8", 32'(adderOut8), 32'h7FFF);
`else
        check("wrapsum", 32'(adderOut0), 32'h8001);
        check("wrapsum_frac8", 32'(adderOut8), 32'h7DFF);
`endif
        tick();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
